// File: rtl/latency_probe.sv
// ============================================================================
// Module   : latency_probe
// Purpose  : One-stage AXI-stream pass-through. It measures the latency of a
//            timestamped beat and keeps min/max/sum/count statistics.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module latency_probe #(
    parameter logic [31:0] MARKER     = 32'hABCDBEEF,
    parameter int unsigned BEAT_INDEX = 1,
    parameter int unsigned SUM_WIDTH  = 48
) (
    input  logic        ce_clk,
    input  logic        ce_rst,
    input  logic [63:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [63:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    input  logic [63:0] timer,
    input  logic        enable,
    input  logic        clear_stats,
    input  logic [2:0]  rb_addr,
    output logic [63:0] rb_data
);

    localparam logic [7:0]  c_BEAT_IDX = 8'(BEAT_INDEX);
    localparam logic [31:0] c_ONES32   = 32'hFFFF_FFFF;

    logic [63:0]          tdata_q, tdata_d;
    logic                 tlast_q, tlast_d;
    logic                 tvalid_q, tvalid_d;
    logic [7:0]           beat_cnt_q, beat_cnt_d;
    logic                 hit_done_q, hit_done_d;
    logic                 hit_q, hit_d;
    logic [31:0]          lat_q, lat_d;
    logic [31:0]          count_q, count_d;
    logic [SUM_WIDTH-1:0] sum_q, sum_d;
    logic [31:0]          last_q, last_d;
    logic [31:0]          min_q, min_d;
    logic [31:0]          max_q, max_d;
    logic [31:0]          misplaced_q, misplaced_d;
    logic [63:0]          rb_data_q, rb_data_d;

    logic                 w_accept;
    logic                 w_marker;
    logic                 w_at_idx;
    logic                 w_hit;
    logic                 w_misplaced;
    logic [SUM_WIDTH:0]   w_sum_ext;

    // Only the low timer word takes part in the latency arithmetic.
    logic unused_timer_hi;
    assign unused_timer_hi = &{1'b0, timer[63:32]};

    assign i_tready = !tvalid_q || o_tready;
    assign o_tdata  = tdata_q;
    assign o_tlast  = tlast_q;
    assign o_tvalid = tvalid_q;
    assign rb_data  = rb_data_q;

    always_comb begin
        w_accept    = i_tvalid && i_tready;
        w_marker    = (i_tdata[63:32] == MARKER);
        w_at_idx    = (beat_cnt_q == c_BEAT_IDX);
        w_hit       = w_accept && w_marker && enable && w_at_idx && !hit_done_q;
        w_misplaced = w_accept && w_marker && enable && !w_at_idx;
        w_sum_ext   = {1'b0, sum_q} + {{(SUM_WIDTH-31){1'b0}}, lat_q};

        tdata_d     = tdata_q;
        tlast_d     = tlast_q;
        tvalid_d    = tvalid_q;
        beat_cnt_d  = beat_cnt_q;
        hit_done_d  = hit_done_q;
        hit_d       = w_hit && !clear_stats;
        // Subtraction wraps modulo 2^32, so a timer rollover still gives a small latency.
        lat_d       = timer[31:0] - i_tdata[31:0];
        count_d     = count_q;
        sum_d       = sum_q;
        last_d      = last_q;
        min_d       = min_q;
        max_d       = max_q;
        misplaced_d = misplaced_q;

        if (w_accept) begin
            tdata_d  = i_tdata;
            tlast_d  = i_tlast;
            tvalid_d = 1'b1;
            if (i_tlast) begin
                beat_cnt_d = 8'd0;
                hit_done_d = 1'b0;
            end else begin
                if (beat_cnt_q != 8'hFF) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                end
                if (w_hit) begin
                    hit_done_d = 1'b1;
                end
            end
        end else if (o_tready) begin
            tvalid_d = 1'b0;
        end

        if (clear_stats) begin
            count_d     = 32'd0;
            sum_d       = '0;
            last_d      = 32'd0;
            min_d       = c_ONES32;
            max_d       = 32'd0;
            misplaced_d = 32'd0;
        end else begin
            if (hit_q) begin
                last_d  = lat_q;
                min_d   = (lat_q < min_q) ? lat_q : min_q;
                max_d   = (lat_q > max_q) ? lat_q : max_q;
                count_d = (count_q == c_ONES32) ? count_q : count_q + 32'd1;
                sum_d   = w_sum_ext[SUM_WIDTH] ? '1 : w_sum_ext[SUM_WIDTH-1:0];
            end
            if (w_misplaced && misplaced_q != c_ONES32) begin
                misplaced_d = misplaced_q + 32'd1;
            end
        end

        case (rb_addr)
            3'd0:    rb_data_d = {32'd0, count_q};
            3'd1:    rb_data_d = {32'd0, last_q};
            3'd2:    rb_data_d = {32'd0, min_q};
            3'd3:    rb_data_d = {32'd0, max_q};
            3'd4:    rb_data_d = 64'(sum_q);
            3'd5:    rb_data_d = {32'd0, misplaced_q};
            3'd6:    rb_data_d = {MARKER, 24'd0, c_BEAT_IDX};
            default: rb_data_d = 64'h0BAD_C0DE_0BAD_C0DE;
        endcase
    end

    always_ff @(posedge ce_clk) begin
        if (ce_rst) begin
            tdata_q     <= 64'd0;
            tlast_q     <= 1'b0;
            tvalid_q    <= 1'b0;
            beat_cnt_q  <= 8'd0;
            hit_done_q  <= 1'b0;
            hit_q       <= 1'b0;
            lat_q       <= 32'd0;
            count_q     <= 32'd0;
            sum_q       <= '0;
            last_q      <= 32'd0;
            min_q       <= c_ONES32;
            max_q       <= 32'd0;
            misplaced_q <= 32'd0;
            rb_data_q   <= 64'd0;
        end else begin
            tdata_q     <= tdata_d;
            tlast_q     <= tlast_d;
            tvalid_q    <= tvalid_d;
            beat_cnt_q  <= beat_cnt_d;
            hit_done_q  <= hit_done_d;
            hit_q       <= hit_d;
            lat_q       <= lat_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            last_q      <= last_d;
            min_q       <= min_d;
            max_q       <= max_d;
            misplaced_q <= misplaced_d;
            rb_data_q   <= rb_data_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_latency_probe.sv
// ============================================================================
// Module   : tb_latency_probe
// Purpose  : Directed self-checking bench for latency_probe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_latency_probe;

    localparam logic [31:0] M = 32'hABCDBEEF;

    logic        ce_clk = 1'b0;
    logic        ce_rst;
    logic [63:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        i_tready;
    logic [63:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;
    logic [63:0] timer;
    logic        enable;
    logic        clear_stats;
    logic [2:0]  rb_addr;
    logic [63:0] rb_data;

    int n_assert = 0;
    int n_fail   = 0;

    latency_probe dut (
        .ce_clk      (ce_clk),
        .ce_rst      (ce_rst),
        .i_tdata     (i_tdata),
        .i_tlast     (i_tlast),
        .i_tvalid    (i_tvalid),
        .i_tready    (i_tready),
        .o_tdata     (o_tdata),
        .o_tlast     (o_tlast),
        .o_tvalid    (o_tvalid),
        .o_tready    (o_tready),
        .timer       (timer),
        .enable      (enable),
        .clear_stats (clear_stats),
        .rb_addr     (rb_addr),
        .rb_data     (rb_data)
    );

    always #5 ce_clk = ~ce_clk;

    task automatic tick();
        @(posedge ce_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One beat accepted at the next edge; the output must show it right after.
    task automatic send(input string tag, input logic [63:0] d, input logic l, input logic [31:0] t);
        i_tvalid = 1'b1;
        i_tdata  = d;
        i_tlast  = l;
        timer    = {32'h5A5A_0000, t};
        tick();
        check({tag, "_data"}, o_tdata, d);
        check({tag, "_valid"}, {63'd0, o_tvalid}, 64'd1);
    endtask

    task automatic idle();
        i_tvalid = 1'b0;
        tick();
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [63:0] exp);
        rb_addr = a;
        tick();
        check(tag, rb_data, exp);
    endtask

    task automatic clr();
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
    endtask

    initial begin
        ce_rst = 1'b1; i_tdata = '0; i_tlast = 0; i_tvalid = 0; o_tready = 1;
        timer = '0; enable = 1; clear_stats = 0; rb_addr = 3'd0;
        tick(); tick();
        check("rst_tvalid", {63'd0, o_tvalid}, 64'd0);
        check("rst_tdata", o_tdata, 64'd0);
        check("rst_rb", rb_data, 64'd0);
        ce_rst = 1'b0;
        tick();
        check("post_rst_tready", {63'd0, i_tready}, 64'd1);
        rd("rst_min", 3'd2, 64'hFFFF_FFFF);
        rd("rst_count", 3'd0, 64'd0);

        // Basic 3-beat packet with latency 0x96-0x64 = 50
        send("p1b0", 64'h1111_2222_3333_4444, 1'b0, 32'h10);
        send("p1b1", {M, 32'h64}, 1'b0, 32'h96);
        send("p1b2", 64'h5555_6666_7777_8888, 1'b1, 32'h20);
        check("p1_tlast", {63'd0, o_tlast}, 64'd1);
        idle();
        check("p1_drain", {63'd0, o_tvalid}, 64'd0);
        rd("p1_count", 3'd0, 64'd1);
        rd("p1_last", 3'd1, 64'd50);
        rd("p1_min", 3'd2, 64'd50);
        rd("p1_max", 3'd3, 64'd50);
        rd("p1_sum", 3'd4, 64'd50);

        // Timer wrap
        send("p2b0", 64'h0000_0000_0000_0001, 1'b0, 32'h0);
        send("p2b1", {M, 32'hFFFF_FFF0}, 1'b1, 32'h10);
        idle();
        rd("wrap_last", 3'd1, 64'h20);
        rd("wrap_misplaced", 3'd5, 64'd0);
        rd("wrap_count", 3'd0, 64'd2);
        rd("wrap_min", 3'd2, 64'd32);

        // Backpressure: A is held for 5 cycles, B waits upstream
        o_tready = 1'b0;
        send("bpA", 64'hAAAA, 1'b0, 32'h0);
        i_tdata = 64'hBBBB;
        for (int k = 0; k < 5; k++) begin
            check("bp_tready", {63'd0, i_tready}, 64'd0);
            check("bp_hold", o_tdata, 64'hAAAA);
            tick();
        end
        o_tready = 1'b1;
        send("bpB", 64'hBBBB, 1'b0, 32'h0);
        send("bpC", 64'hCCCC, 1'b0, 32'h0);
        send("bpD", 64'hDDDD, 1'b1, 32'h0);
        idle();
        check("bp_drain", {63'd0, o_tvalid}, 64'd0);

        // Marker on beats 0 and 2 only
        clr();
        send("mp0", {M, 32'd0}, 1'b0, 32'd9);
        send("mp1", 64'h1234, 1'b0, 32'd9);
        send("mp2", {M, 32'd5}, 1'b1, 32'd9);
        idle();
        rd("mp_misplaced", 3'd5, 64'd2);
        rd("mp_count", 3'd0, 64'd0);

        // Hit coincident with clear_stats is dropped
        send("cc0", 64'h1, 1'b0, 32'd0);
        clear_stats = 1'b1;
        send("cc1", {M, 32'd100}, 1'b0, 32'd105);
        clear_stats = 1'b0;
        send("cc2", 64'h2, 1'b1, 32'd0);
        idle();
        rd("cc_count", 3'd0, 64'd0);
        rd("cc_min", 3'd2, 64'hFFFF_FFFF);
        rd("cc_misplaced", 3'd5, 64'd0);
        send("cn0", 64'h3, 1'b0, 32'd0);
        send("cn1", {M, 32'd1000}, 1'b1, 32'd1007);
        idle();
        rd("cn_count", 3'd0, 64'd1);
        rd("cn_min", 3'd2, 64'd7);
        rd("cn_max", 3'd3, 64'd7);

        // enable low: no measurement
        enable = 1'b0;
        send("en0", 64'h4, 1'b0, 32'd0);
        send("en1", {M, 32'd0}, 1'b1, 32'd99);
        idle();
        enable = 1'b1;
        rd("en_count", 3'd0, 64'd1);

        // Latencies 10, 3, 25 then a readback sweep
        clr();
        send("s1a", 64'h5, 1'b0, 32'd0);
        send("s1b", {M, 32'd200}, 1'b1, 32'd210);
        send("s2a", 64'h6, 1'b0, 32'd0);
        send("s2b", {M, 32'd50}, 1'b1, 32'd53);
        send("s3a", 64'h7, 1'b0, 32'd0);
        send("s3b", {M, 32'd1000}, 1'b1, 32'd1025);
        idle();
        rd("sw0", 3'd0, 64'd3);
        rd("sw1", 3'd1, 64'd25);
        rd("sw2", 3'd2, 64'd3);
        rd("sw3", 3'd3, 64'd25);
        rd("sw4", 3'd4, 64'd38);
        rd("sw5", 3'd5, 64'd0);
        rd("sw6", 3'd6, 64'hABCD_BEEF_0000_0001);
        rd("sw7", 3'd7, 64'h0BAD_C0DE_0BAD_C0DE);

        // Reset mid-packet: next accepted beat is beat 0, so a marker there is misplaced
        send("rm0", 64'h8, 1'b0, 32'd0);
        i_tvalid = 1'b0;
        ce_rst = 1'b1;
        tick();
        check("rm_tvalid", {63'd0, o_tvalid}, 64'd0);
        check("rm_tdata", o_tdata, 64'd0);
        ce_rst = 1'b0;
        tick();
        send("rm1", {M, 32'd0}, 1'b1, 32'd4);
        idle();
        rd("rm_misplaced", 3'd5, 64'd1);
        rd("rm_count", 3'd0, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/latency_probe.md
LATENCY_PROBE -- requirements
Module: latency_probe

Interface
REQ-001 The module SHALL have parameter MARKER, default 32'hABCDBEEF: value of tdata[63:32] that identifies a timestamped beat.
REQ-002 The module SHALL have parameter BEAT_INDEX, default 1: zero-based beat position within a packet that is inspected for MARKER.
REQ-003 The module SHALL have parameter SUM_WIDTH, default 48: width of the latency accumulator.
REQ-004 The module SHALL have port ce_clk, input, 1: sole clock; all logic is rising-edge.
REQ-005 The module SHALL have port ce_rst, input, 1: synchronous, active-high reset.
REQ-006 The module SHALL have ports i_tdata input 64, i_tlast input 1, i_tvalid input 1 and i_tready output 1: upstream AXI-stream.
REQ-007 The module SHALL have ports o_tdata output 64, o_tlast output 1, o_tvalid output 1 and o_tready input 1: downstream AXI-stream.
REQ-008 The module SHALL have port timer, input, 64: free-running ce_clk tick counter; only bits [31:0] are used.
REQ-009 The module SHALL have port enable, input, 1: when low, no measurements are recorded (pass-through continues).
REQ-010 The module SHALL have port clear_stats, input, 1: single-cycle strobe that resets all statistics.
REQ-011 The module SHALL have port rb_addr, input, 3: readback select.
REQ-012 The module SHALL have port rb_data, output, 64: registered readback value.

Function
REQ-013 Pass-through SHALL be a single register stage: a beat is accepted when i_tvalid && i_tready, and o_tdata/o_tlast SHALL equal the accepted beat unmodified.
REQ-014 i_tready SHALL equal !o_tvalid || o_tready; the stage SHALL sustain one beat per cycle with no bubbles.
REQ-015 o_tvalid SHALL set on acceptance and clear when o_tready is high with no new acceptance; o_tdata SHALL hold stable while o_tvalid && !o_tready.
REQ-016 Latency from input acceptance to o_tvalid SHALL be exactly 1 cycle.
REQ-017 An 8-bit beat counter SHALL increment on every accepted beat, return to 0 on an accepted beat with i_tlast=1, and saturate at 255.
REQ-018 A hit SHALL be an accepted beat with beat counter == BEAT_INDEX, i_tdata[63:32] == MARKER and enable=1; at most one hit per packet.
REQ-019 Hit latency SHALL be timer[31:0] − i_tdata[31:0] sampled in the acceptance cycle, computed modulo 2^32 so that timer wrap yields the correct small value.
REQ-020 Statistics SHALL update in the cycle after the hit: last := latency; min := min(min, latency); max := max(max, latency); count := count+1 saturating at 32'hFFFFFFFF; sum := sum+latency saturating at all-ones.
REQ-021 An accepted beat whose tdata[63:32] == MARKER at any other beat position SHALL increment a 32-bit saturating misplaced counter and SHALL NOT update the latency statistics.
REQ-022 clear_stats SHALL set count=0, sum=0, last=0, min=32'hFFFFFFFF, max=0 and misplaced=0 on the next edge; a hit in the same cycle as clear_stats SHALL be discarded.
REQ-023 clear_stats SHALL NOT affect the data path or the beat counter.
REQ-024 rb_data SHALL update one cycle after rb_addr, with the following mapping: 0 {32'd0,count}; 1 {32'd0,last}; 2 {32'd0,min}; 3 {32'd0,max}; 4 sum zero-extended; 5 {32'd0,misplaced}; 6 {MARKER,24'd0,BEAT_INDEX[7:0]}; 7 64'h0BADC0DE0BADC0DE.

Reset
REQ-025 During ce_rst, o_tvalid=0, o_tdata=0, o_tlast=0, beat counter=0, count=sum=last=max=misplaced=0, min=32'hFFFFFFFF and rb_data=0.
REQ-026 Reset asserted mid-packet SHALL discard the held beat; the first beat accepted after reset SHALL be beat 0.
REQ-027 i_tready SHALL be 1 in the cycle after reset deasserts.

Verification
REQ-028 3-beat packet with beat1 = {ABCDBEEF,00000064} and timer=0x96 at acceptance -> o_tdata reproduces all 3 beats 1 cycle late; count=1, last=min=max=50, sum=50.
REQ-029 Stamp 0xFFFFFFF0 with timer[31:0]=0x00000010 -> last=0x20 (wrap handled); misplaced unchanged.
REQ-030 o_tready held low for 5 cycles mid-packet -> i_tready=0 after the first held beat, o_tdata stable, and no beat lost or duplicated when released.
REQ-031 Marker on beat 0 and on beat 2, enable=1 -> misplaced=2, count=0.
REQ-032 Hit coincident with clear_stats -> count=0 and min=FFFFFFFF; the next hit with latency 7 gives count=1 and min=max=7.
REQ-033 Hits with latencies 10, 3 and 25, then rb_addr sweeps 0-7 -> rb_data one cycle later reads 3, 25, 3, 25, 38, 0, ABCDBEEF_00000001, 0BADC0DE0BADC0DE.
